// File: rtl/aud_sram_arb.sv
// Round-robin arbiter and access sequencer for the shared audio SRAM.
// The recorder owns writes, the playback DSP owns reads. Every access is followed by one idle turnaround cycle.
module aud_sram_arb #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int ACCESS_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rec_en,
  input  logic              i_play_en,
  input  logic              i_rec_req,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [DATA_W-1:0] i_rec_data,
  output logic              o_rec_ack,
  input  logic              i_play_req,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic [DATA_W-1:0] o_play_data,
  output logic              o_play_valid,
  output logic [ADDR_W-1:0] o_last_wr_addr,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2} state_t;
  typedef enum logic {RR_READ = 1'b0, RR_WRITE = 1'b1} rr_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYC - 1);
  localparam logic [3:0] WE_END   = 4'(ACCESS_CYC - 2);

  state_t              state_r;
  rr_t                 rr_last_r;
  logic [3:0]          cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   play_data_r;
  logic [ADDR_W-1:0]   last_wr_addr_r;
  logic                rec_ack_r;
  logic                play_valid_r;
  logic                busy_r;
  logic                dq_oe_r;
  logic                ce_n_r;
  logic                oe_n_r;
  logic                we_n_r;
  logic                byte_n_r;
  logic                rd_ok_s;
  logic                wr_ok_s;
  logic                grant_rd_s;
  logic                grant_wr_s;

  // Eligibility and round-robin grant decision (only acted upon in S_IDLE)
  always_comb begin
    rd_ok_s    = i_play_req & i_play_en;
    wr_ok_s    = i_rec_req & i_rec_en;
    grant_rd_s = 1'b0;
    grant_wr_s = 1'b0;
    if (rd_ok_s && wr_ok_s) begin
      if (rr_last_r == RR_WRITE) begin
        grant_rd_s = 1'b1;
      end else begin
        grant_wr_s = 1'b1;
      end
    end else begin
      grant_rd_s = rd_ok_s;
      grant_wr_s = wr_ok_s;
    end
  end

  // Access sequencer: state, counter, SRAM strobes and requester handshakes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r        <= S_IDLE;
      rr_last_r      <= RR_WRITE;
      cnt_r          <= 4'd0;
      addr_r         <= '0;
      wdata_r        <= '0;
      play_data_r    <= '0;
      last_wr_addr_r <= '0;
      rec_ack_r      <= 1'b0;
      play_valid_r   <= 1'b0;
      busy_r         <= 1'b0;
      dq_oe_r        <= 1'b0;
      ce_n_r         <= 1'b1;
      oe_n_r         <= 1'b1;
      we_n_r         <= 1'b1;
      byte_n_r       <= 1'b1;
    end else begin
      rec_ack_r    <= 1'b0;
      play_valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          cnt_r <= 4'd0;
          if (grant_rd_s) begin
            state_r  <= S_READ;
            addr_r   <= i_play_addr;
            ce_n_r   <= 1'b0;
            oe_n_r   <= 1'b0;
            we_n_r   <= 1'b1;
            byte_n_r <= 1'b0;
            dq_oe_r  <= 1'b0;
            busy_r   <= 1'b1;
            if (wr_ok_s) rr_last_r <= RR_READ;
          end else if (grant_wr_s) begin
            state_r  <= S_WRITE;
            addr_r   <= i_rec_addr;
            wdata_r  <= i_rec_data;
            ce_n_r   <= 1'b0;
            oe_n_r   <= 1'b1;
            we_n_r   <= 1'b0;
            byte_n_r <= 1'b0;
            dq_oe_r  <= 1'b1;
            busy_r   <= 1'b1;
            if (rd_ok_s) rr_last_r <= RR_WRITE;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_READ: begin
          if (cnt_r == LAST_CNT) begin
            play_data_r  <= i_sram_rdata;
            play_valid_r <= 1'b1;
            state_r      <= S_IDLE;
            cnt_r        <= 4'd0;
            ce_n_r       <= 1'b1;
            oe_n_r       <= 1'b1;
            we_n_r       <= 1'b1;
            byte_n_r     <= 1'b1;
            dq_oe_r      <= 1'b0;
            busy_r       <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        S_WRITE: begin
          if (cnt_r == LAST_CNT) begin
            rec_ack_r      <= 1'b1;
            last_wr_addr_r <= addr_r;
            state_r        <= S_IDLE;
            cnt_r          <= 4'd0;
            ce_n_r         <= 1'b1;
            oe_n_r         <= 1'b1;
            we_n_r         <= 1'b1;
            byte_n_r       <= 1'b1;
            dq_oe_r        <= 1'b0;
            busy_r         <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
            // Release we_n one cycle early so data is held past the write pulse
            if (cnt_r == WE_END) we_n_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= S_IDLE;
          cnt_r    <= 4'd0;
          ce_n_r   <= 1'b1;
          oe_n_r   <= 1'b1;
          we_n_r   <= 1'b1;
          byte_n_r <= 1'b1;
          dq_oe_r  <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign o_rec_ack      = rec_ack_r;
  assign o_play_data    = play_data_r;
  assign o_play_valid   = play_valid_r;
  assign o_last_wr_addr = last_wr_addr_r;
  assign o_busy         = busy_r;
  assign o_sram_addr    = addr_r;
  assign o_sram_wdata   = wdata_r;
  assign o_sram_dq_oe   = dq_oe_r;
  assign o_sram_ce_n    = ce_n_r;
  assign o_sram_oe_n    = oe_n_r;
  assign o_sram_we_n    = we_n_r;
  assign o_sram_lb_n    = byte_n_r;
  assign o_sram_ub_n    = byte_n_r;

endmodule
